spike_rate_monitor: RTL and testbench
=====================================

Name: spike_rate_monitor

Overview:
- Downstream consumer of the LIF neuron chain's spike outputs.
- Counts rising edges on each spike line over a programmable window of clock cycles.
- At each window end it snapshots the per-channel spike counts (firing rates) and offers them through a valid/ready handshake to the readout logic (7-seg/uio mux or host scan).
- A sticky overrun flag reports any unconsumed snapshot that was overwritten.

Parameters:
- NUM_CH, 3, number of spike inputs (one per LIF instance)
- CNT_W, 8, width of each per-channel spike count; counts saturate
- WIN_W, 8, width of window length input

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  count enable; low freezes window and spike counters
- spike_in  input  NUM_CH  raw spike levels from LIF neurons, bit i = neuron i
- win_len  input  WIN_W  window length in cycles; 0 = monitoring halted
- rate_ready  input  1  consumer accepts snapshot
- clr_ovr  input  1  synchronous clear of overrun flag
- rate_valid  output  1  snapshot available
- rate_out  output  NUM_CH*CNT_W  snapshot; channel i at bits [i*CNT_W +: CNT_W]
- overrun  output  1  sticky: snapshot overwritten while unconsumed
- win_tick  output  1  one-cycle pulse on window-end cycle

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous and active-low, on rst_n.
- Reset values:
  - rate_valid=0, rate_out=0, overrun=0, win_tick=0.
  - Window counter=0, all spike counters=0.
  - Edge-detect history registers=0, so a spike held high through reset release counts as one edge.
- Edge detection: per channel, edge_i = spike_in[i] & ~prev_i. prev_i updates every cycle, including when ena=0, so no edge is lost or double-counted across enable gaps.
- Spike counters:
  - When ena=1, edge_i increments count_i.
  - Saturates at 2^CNT_W-1; no wrap.
  - When ena=0, counters hold and edges are ignored.
- Window counter:
  - win_len is latched into len_q at reset release and at every window end.
  - When ena=1 and len_q!=0, the counter increments.
  - Window-end cycle is when counter==len_q-1 and ena=1. On that cycle the counter returns to 0.
  - When len_q==0, the counter holds 0, no window ends occur, and len_q reloads from win_len every cycle until it is nonzero.
- Window-end cycle (win_tick registered; asserted the cycle after, aligned with snapshot):
  - snap_i = sat(count_i + edge_i); an edge in the final window cycle belongs to the closing window.
  - count_i is cleared to 0 for the next window.
- Snapshot latency: rate_out and rate_valid update on the clock edge ending the window-end cycle. They are visible 1 cycle later, in the same cycle as win_tick.
- Handshake:
  - rate_valid stays high until the cycle where rate_valid & rate_ready; it clears after that edge.
  - rate_out is stable while rate_valid=1 unless overwritten.
  - A new snapshot while rate_valid=1 and rate_ready=1 in the same cycle: load the new snapshot, rate_valid remains 1, no overrun.
  - A new snapshot while rate_valid=1 and rate_ready=0: overwrite rate_out, set overrun.
- Overrun:
  - Sticky; cleared only by clr_ovr or reset.
  - If clr_ovr and a new overrun event occur together, set wins.
- Width rule: len_q=1 means every enabled cycle is a window end; snapshot per channel is then 0 or 1.
- Reset mid-window: all state clears immediately and the partial window is discarded. After rst_n rises, the first enabled cycle is window cycle 0.
- win_len change mid-window: no effect until the next window end.

Decomposition:
- Package lif_mon_pkg holds:
  - default constants NUM_CH_D=3, CNT_W_D=8, WIN_W_D=8
  - function sat_inc(count, inc) returning the saturated sum
- One sub-module, spike_edge_counter:
  - contains the prev register, edge detect, saturating counter, and clear-on-window-end
  - instantiated NUM_CH times by a generate loop
- Top-level spike_rate_monitor keeps the window counter, snapshot register, handshake and overrun logic.

Test Plan:
- Basic window: win_len=10, ena=1, ch0 1-cycle pulses at window cycles 1,4,7; ch1 held high all window; ch2 idle -> win_tick after cycle 9; rate_out ch0=3, ch1=1, ch2=0; rate_valid=1 until rate_ready is pulsed.
- Boundary edge: win_len=5, ch0 edge only in window cycle 4 -> snapshot ch0=1; next window (no spikes) snapshot ch0=0.
- Saturation: CNT_W=8, win_len=0 then 255 toggled... use win_len=255 with ch0 toggling every cycle (128 edges) and CNT_W=4 build -> ch0 snapshot=15.
- Overrun and simultaneity:
  - win_len=4, rate_ready=0 for 3 windows -> overrun=1 after the 2nd snapshot; rate_out equals the latest window.
  - clr_ovr -> overrun=0.
  - Ready asserted exactly in the window-end+1 cycle -> no overrun, valid stays 1.
- Enable gap: win_len=6, ena low for 4 cycles mid-window with ch0 pulses during the gap -> gap edges ignored; window length in enabled cycles still 6; a spike held high across ena rising is not recounted.
- Async reset mid-window: assert rst_n=0 between clock edges at window cycle 3 -> all outputs 0 immediately; first snapshot after release covers a full fresh window; win_len=0 -> no win_tick for 50 cycles.

Source files
------------

// File: rtl/lif_mon_pkg.sv
// Shared constants and helpers for the spike rate monitor.
// Holds the default channel, count and window widths plus the saturating add.
package lif_mon_pkg;

    localparam int unsigned NUM_CH_D = 3;
    localparam int unsigned CNT_W_D  = 8;
    localparam int unsigned WIN_W_D  = 8;

    // Saturates at 2^width-1; width must not exceed 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, count} + {32'd0, inc};
        max = (33'd1 << width) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/spike_edge_counter.sv
// One spike channel: rising-edge detector plus saturating counter.
// The counter is cleared at window end; snap is the closing value including this cycle's edge.
module spike_edge_counter
    import lif_mon_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike,
    input  logic             win_end,
    output logic [CNT_W-1:0] snap
);

    logic             prev_q;
    logic             spike_edge;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign spike_edge = spike & ~prev_q;
    assign snap       = CNT_W'(sat_inc(32'(count_q), spike_edge, CNT_W));

    always_comb begin
        count_d = count_q;
        if (ena) begin
            count_d = win_end ? '0 : snap;
        end
    end

    // prev tracks the line even while disabled so edges are never recounted after a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            prev_q  <= spike;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spike_rate_monitor.sv
// Windowed spike-rate monitor: per-channel edge counts snapshotted every win_len enabled cycles
// and offered over valid/ready, with a sticky overrun flag for overwritten snapshots.
module spike_rate_monitor
    import lif_mon_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_D,
    parameter int unsigned CNT_W  = CNT_W_D,
    parameter int unsigned WIN_W  = WIN_W_D
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [NUM_CH-1:0]       spike_in,
    input  logic [WIN_W-1:0]        win_len,
    input  logic                    rate_ready,
    input  logic                    clr_ovr,
    output logic                    rate_valid,
    output logic [NUM_CH*CNT_W-1:0] rate_out,
    output logic                    overrun,
    output logic                    win_tick
);

    logic [WIN_W-1:0]        len_q;
    logic [WIN_W-1:0]        len_d;
    logic [WIN_W-1:0]        len_eff;
    logic [WIN_W-1:0]        win_cnt_q;
    logic [WIN_W-1:0]        win_cnt_d;
    logic                    win_end;
    logic [NUM_CH*CNT_W-1:0] snap;
    logic [NUM_CH*CNT_W-1:0] rate_q;
    logic [NUM_CH*CNT_W-1:0] rate_d;
    logic                    valid_q;
    logic                    valid_d;
    logic                    ovr_q;
    logic                    ovr_d;
    logic                    tick_q;

    // While len_q is still 0 the live win_len is used, so the cycle after reset release
    // (or after a halt) is already window cycle 0.
    assign len_eff = (len_q != '0) ? len_q : win_len;
    assign win_end = ena && (len_eff != '0) && (win_cnt_q == len_eff - WIN_W'(1));

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (ena && (len_eff != '0)) begin
            win_cnt_d = win_end ? '0 : win_cnt_q + WIN_W'(1);
        end
        len_d = (win_end || (len_q == '0)) ? win_len : len_q;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        spike_edge_counter #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena),
            .spike   (spike_in[i]),
            .win_end (win_end),
            .snap    (snap[i*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        rate_d  = rate_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && rate_ready) begin
            valid_d = 1'b0;
        end
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end
        // A new snapshot overrides the consume; overrun setting wins over clr_ovr.
        if (win_end) begin
            rate_d  = snap;
            valid_d = 1'b1;
            if (valid_q && !rate_ready) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            win_cnt_q <= '0;
            rate_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            len_q     <= len_d;
            win_cnt_q <= win_cnt_d;
            rate_q    <= rate_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            tick_q    <= win_end;
        end
    end

    assign rate_valid = valid_q;
    assign rate_out   = rate_q;
    assign overrun    = ovr_q;
    assign win_tick   = tick_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Scoreboard bench for spike_rate_monitor built with 4-bit counters so saturation is reachable.
// Stimulus pushes hand-computed snapshots; a monitor compares them whenever win_tick fires.
module tb_spike_rate_monitor;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WIN_W  = 8;

    logic                    clk;
    logic                    rst_n;
    logic                    ena;
    logic [NUM_CH-1:0]       spike_in;
    logic [WIN_W-1:0]        win_len;
    logic                    rate_ready;
    logic                    clr_ovr;
    logic                    rate_valid;
    logic [NUM_CH*CNT_W-1:0] rate_out;
    logic                    overrun;
    logic                    win_tick;

    int n_chk  = 0;
    int n_pass = 0;
    int tick_cnt = 0;
    logic [NUM_CH*CNT_W-1:0] exp_q[$];

    spike_rate_monitor #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .WIN_W  (WIN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .spike_in   (spike_in),
        .win_len    (win_len),
        .rate_ready (rate_ready),
        .clr_ovr    (clr_ovr),
        .rate_valid (rate_valid),
        .rate_out   (rate_out),
        .overrun    (overrun),
        .win_tick   (win_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic logic [11:0] pk(input int c2, input int c1, input int c0);
        return {4'(c2), 4'(c1), 4'(c0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at window cycle 0 with all inputs idle.
    task automatic do_reset(input logic [WIN_W-1:0] len);
        rst_n      = 1'b0;
        ena        = 1'b1;
        spike_in   = '0;
        rate_ready = 1'b0;
        clr_ovr    = 1'b0;
        win_len    = len;
        #1;
        check("reset_valid", 32'(rate_valid), 0);
        check("reset_rate", 32'(rate_out), 0);
        check("reset_overrun", 32'(overrun), 0);
        check("reset_tick", 32'(win_tick), 0);
        step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && win_tick) begin
            tick_cnt++;
            check("snapshot_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("snapshot_rate", 32'(rate_out), 32'(exp_q.pop_front()));
                check("snapshot_valid", 32'(rate_valid), 1);
            end
        end
    end

    logic [3:0] gap_v [10] = '{4'b1000, 4'b1001, 4'b0000, 4'b0001, 4'b0000,
                               4'b0010, 4'b1010, 4'b1110, 4'b1010, 4'b1010};

    initial begin
        int ticks_before;
        rst_n = 1'b0; ena = 1'b0; spike_in = '0; win_len = '0; rate_ready = 1'b0;
        clr_ovr = 1'b0;

        // Basic window: ch0 pulses at 1,4,7; ch1 held high; ch2 idle.
        do_reset(8'd10);
        exp_q.push_back(pk(0, 1, 3));
        for (int c = 0; c < 10; c++) begin
            spike_in = {1'b0, 1'b1, (c == 1 || c == 4 || c == 7)};
            step();
        end
        check("basic_tick", 32'(win_tick), 1);
        spike_in = '0;
        step(); step(); step();
        check("basic_valid_held", 32'(rate_valid), 1);
        check("basic_tick_pulse", 32'(win_tick), 0);
        rate_ready = 1'b1;
        step();
        rate_ready = 1'b0;
        check("basic_valid_consumed", 32'(rate_valid), 0);

        // Edge only in the final window cycle, then an empty window.
        do_reset(8'd5);
        rate_ready = 1'b1;
        exp_q.push_back(pk(0, 0, 1));
        exp_q.push_back(pk(0, 0, 0));
        for (int c = 0; c < 10; c++) begin
            spike_in = {2'b00, (c == 4)};
            step();
        end
        step();
        check("boundary_overrun", 32'(overrun), 0);

        // Saturation: 20, 14 and 15 edges with 4-bit counters.
        do_reset(8'd40);
        rate_ready = 1'b1;
        exp_q.push_back(pk(15, 14, 15));
        for (int c = 0; c < 40; c++) begin
            spike_in = {(c < 30) && (c % 2 == 1), (c < 28) && (c % 2 == 1), (c % 2 == 1)};
            step();
        end
        step();

        // Overrun, clear, ready coinciding with a new snapshot, set beating clear.
        do_reset(8'd4);
        exp_q.push_back(pk(0, 0, 1));
        exp_q.push_back(pk(0, 0, 2));
        exp_q.push_back(pk(0, 1, 0));
        exp_q.push_back(pk(0, 0, 0));
        exp_q.push_back(pk(1, 0, 0));
        exp_q.push_back(pk(0, 0, 0));
        for (int c = 0; c < 12; c++) begin
            spike_in = {1'b0, (c == 9), (c == 1 || c == 4 || c == 6)};
            step();
            if (c + 1 == 6) check("ovr_after_first", 32'(overrun), 0);
            if (c + 1 == 8) check("ovr_after_second", 32'(overrun), 1);
        end
        spike_in = '0;
        check("ovr_sticky", 32'(overrun), 1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);
        check("ovr_valid_kept", 32'(rate_valid), 1);
        rate_ready = 1'b1;
        step();
        rate_ready = 1'b0;
        check("ovr_consumed", 32'(rate_valid), 0);
        step(); step();
        step();
        spike_in = 3'b100;
        step();
        spike_in = '0;
        step();
        rate_ready = 1'b1;
        step();
        rate_ready = 1'b0;
        check("simul_valid", 32'(rate_valid), 1);
        check("simul_no_ovr", 32'(overrun), 0);
        step(); step(); step();
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("set_beats_clear", 32'(overrun), 1);
        step();

        // Enable gap: window spans 6 enabled cycles; gap edges and held line ignored.
        do_reset(8'd6);
        rate_ready = 1'b1;
        exp_q.push_back(pk(1, 0, 1));
        for (int t = 0; t < 10; t++) begin
            ena      = gap_v[t][3];
            spike_in = gap_v[t][2:0];
            step();
        end
        ena = 1'b1;
        spike_in = '0;
        check("gap_tick", 32'(win_tick), 1);
        step();

        // Asynchronous reset mid-window discards the partial window.
        do_reset(8'd5);
        exp_q.push_back(pk(0, 0, 1));
        for (int c = 0; c < 8; c++) begin
            spike_in = {1'b0, (c == 6), (c == 2)};
            step();
        end
        spike_in = '0;
        check("pre_reset_valid", 32'(rate_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(rate_valid), 0);
        check("async_rate", 32'(rate_out), 0);
        check("async_overrun", 32'(overrun), 0);
        check("async_tick", 32'(win_tick), 0);
        step();
        rst_n = 1'b1;
        exp_q.push_back(pk(1, 0, 1));
        for (int c = 0; c < 5; c++) begin
            spike_in = {(c == 4), 1'b0, (c == 0)};
            step();
        end
        spike_in = '0;
        check("fresh_window_tick", 32'(win_tick), 1);
        step();

        // win_len = 0 halts monitoring.
        do_reset(8'd0);
        ticks_before = tick_cnt;
        for (int c = 0; c < 50; c++) begin
            spike_in = (c % 2 == 1) ? 3'b111 : 3'b000;
            step();
        end
        spike_in = '0;
        check("halt_no_tick", 32'(tick_cnt - ticks_before), 0);
        check("halt_no_valid", 32'(rate_valid), 0);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
